// File: rtl/lms_fir_sequencer.sv
// lms_fir_sequencer
// Time-multiplexed FIR tap sequencer placed directly upstream of the shared MAC.
// It holds the sample delay line and the coefficient bank, and it streams one
// (sample, coefficient) pair per cycle into the MAC.
// The MAC accumulator is never cleared. The dot product for each sample is
// recovered as the difference from the accumulator value captured after the
// previous sample. That result is then rounded, saturated and handed off over
// valid/ready.
module lms_fir_sequencer #(
    parameter int N_TAPS      = 32,
    parameter int SAMPLE_SIZE = 16,
    parameter int COEFF_SIZE  = 17,
    localparam int ACC_W      = SAMPLE_SIZE + COEFF_SIZE,
    localparam int AW         = $clog2(N_TAPS)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SAMPLE_SIZE-1:0] in_sample,
    input  logic                   coef_we,
    input  logic [AW-1:0]          coef_addr,
    input  logic [COEFF_SIZE-1:0]  coef_wdata,
    output logic                   mac_mult_en,
    output logic                   mac_acc_en,
    output logic [COEFF_SIZE-1:0]  mac_c,
    output logic [SAMPLE_SIZE-1:0] mac_s,
    input  logic [ACC_W-1:0]       mac_dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAMPLE_SIZE-1:0] out_sample,
    output logic                   out_sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_SNAP,
        S_OUT
    } state_t;

    localparam logic [AW-1:0]          LAST_TAP = AW'(N_TAPS - 1);
    localparam logic signed [ACC_W:0]  ROUND_K  = (ACC_W + 1)'(1 << (COEFF_SIZE - 2));
    localparam logic signed [ACC_W:0]  SAT_MAX  = (ACC_W + 1)'((1 << (SAMPLE_SIZE - 1)) - 1);
    localparam logic signed [ACC_W:0]  SAT_MIN  = ~SAT_MAX;

    state_t                 state_q, state_d;
    logic [SAMPLE_SIZE-1:0] sample_buf_q [N_TAPS];
    logic [SAMPLE_SIZE-1:0] sample_buf_d [N_TAPS];
    logic [COEFF_SIZE-1:0]  coef_q [N_TAPS];
    logic [COEFF_SIZE-1:0]  coef_d [N_TAPS];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          tap_q, tap_d;
    logic [ACC_W-1:0]       base_q, base_d;
    logic [SAMPLE_SIZE-1:0] out_sample_q, out_sample_d;
    logic                   out_sat_q, out_sat_d;
    logic                   mac_mult_en_q, mac_mult_en_d;
    logic                   mac_acc_en_q, mac_acc_en_d;
    logic [COEFF_SIZE-1:0]  mac_c_q, mac_c_d;
    logic [SAMPLE_SIZE-1:0] mac_s_q, mac_s_d;

    logic [AW-1:0]          next_tap;
    logic [ACC_W-1:0]       sum_w;
    logic signed [ACC_W:0]  round_w;
    logic signed [ACC_W:0]  shifted_w;
    logic                   coef_wr_ok;

    // The per-sample sum is taken as a modular difference, so accumulator wrap cancels out.
    // One extra bit keeps the rounding constant from overflowing near the signed limit.
    assign next_tap   = tap_q + AW'(1);
    assign sum_w      = mac_dout - base_q;
    assign round_w    = $signed({sum_w[ACC_W-1], sum_w}) + ROUND_K;
    assign shifted_w  = round_w >>> (COEFF_SIZE - 1);
    assign coef_wr_ok = (state_q == S_IDLE) && coef_we && (int'(coef_addr) < N_TAPS);

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign out_sample  = out_sample_q;
    assign out_sat     = out_sat_q;
    assign mac_mult_en = mac_mult_en_q;
    assign mac_acc_en  = mac_acc_en_q;
    assign mac_c       = mac_c_q;
    assign mac_s       = mac_s_q;

    // Next-state logic: sequence the taps, recover and round the sum, and handle the handshakes.
    always_comb begin
        state_d       = state_q;
        sample_buf_d  = sample_buf_q;
        coef_d        = coef_q;
        wr_ptr_d      = wr_ptr_q;
        tap_d         = tap_q;
        base_d        = base_q;
        out_sample_d  = out_sample_q;
        out_sat_d     = out_sat_q;
        mac_mult_en_d = 1'b0;
        mac_acc_en_d  = mac_mult_en_q;
        mac_c_d       = mac_c_q;
        mac_s_d       = mac_s_q;

        if (coef_wr_ok) begin
            coef_d[coef_addr] = coef_wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sample_buf_d[wr_ptr_q] = in_sample;
                    tap_d                  = '0;
                    mac_mult_en_d          = 1'b1;
                    mac_s_d                = in_sample;
                    mac_c_d                = coef_d[0];
                    state_d                = S_RUN;
                end
            end
            S_RUN: begin
                if (tap_q == LAST_TAP) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    state_d  = S_DRAIN;
                end else begin
                    tap_d         = next_tap;
                    mac_mult_en_d = 1'b1;
                    mac_s_d       = sample_buf_q[wr_ptr_q - next_tap];
                    mac_c_d       = coef_q[next_tap];
                end
            end
            S_DRAIN: begin
                state_d = S_SNAP;
            end
            S_SNAP: begin
                base_d = mac_dout;
                if (shifted_w > SAT_MAX) begin
                    out_sample_d = {1'b0, {(SAMPLE_SIZE - 1){1'b1}}};
                    out_sat_d    = 1'b1;
                end else if (shifted_w < SAT_MIN) begin
                    out_sample_d = {1'b1, {(SAMPLE_SIZE - 1){1'b0}}};
                    out_sat_d    = 1'b1;
                end else begin
                    out_sample_d = shifted_w[SAMPLE_SIZE-1:0];
                    out_sat_d    = 1'b0;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. They share the MAC's async reset, so a cleared base matches a cleared accumulator.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < N_TAPS; i++) begin
                sample_buf_q[i] <= '0;
                coef_q[i]       <= '0;
            end
            wr_ptr_q      <= '0;
            tap_q         <= '0;
            base_q        <= '0;
            out_sample_q  <= '0;
            out_sat_q     <= 1'b0;
            mac_mult_en_q <= 1'b0;
            mac_acc_en_q  <= 1'b0;
            mac_c_q       <= '0;
            mac_s_q       <= '0;
        end else begin
            state_q       <= state_d;
            sample_buf_q  <= sample_buf_d;
            coef_q        <= coef_d;
            wr_ptr_q      <= wr_ptr_d;
            tap_q         <= tap_d;
            base_q        <= base_d;
            out_sample_q  <= out_sample_d;
            out_sat_q     <= out_sat_d;
            mac_mult_en_q <= mac_mult_en_d;
            mac_acc_en_q  <= mac_acc_en_d;
            mac_c_q       <= mac_c_d;
            mac_s_q       <= mac_s_d;
        end
    end

endmodule

// File: tb/tb_lms_fir_sequencer.sv
// tb_lms_fir_sequencer
// Directed bench for lms_fir_sequencer.
// It includes a behavioural two-stage MAC: a product register followed by an
// accumulator that is never cleared. It also includes a reference FIR model
// for the long randomised run.
`timescale 1ns/1ps
module tb_lms_fir_sequencer;

    localparam int N_TAPS      = 32;
    localparam int SAMPLE_SIZE = 16;
    localparam int COEFF_SIZE  = 17;
    localparam int ACC_W       = SAMPLE_SIZE + COEFF_SIZE;
    localparam int AW          = $clog2(N_TAPS);

    logic                   clk = 1'b0;
    logic                   nrst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [SAMPLE_SIZE-1:0] in_sample = '0;
    logic                   coef_we = 1'b0;
    logic [AW-1:0]          coef_addr = '0;
    logic [COEFF_SIZE-1:0]  coef_wdata = '0;
    logic                   mac_mult_en;
    logic                   mac_acc_en;
    logic [COEFF_SIZE-1:0]  mac_c;
    logic [SAMPLE_SIZE-1:0] mac_s;
    logic [ACC_W-1:0]       mac_dout;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [SAMPLE_SIZE-1:0] out_sample;
    logic                   out_sat;

    logic signed [ACC_W-1:0] mac_prod;
    logic signed [ACC_W-1:0] mac_acc;

    int cmp_cnt = 0;
    int err_cnt = 0;

    longint ref_x [N_TAPS];
    longint ref_c [N_TAPS];

    lms_fir_sequencer #(
        .N_TAPS(N_TAPS),
        .SAMPLE_SIZE(SAMPLE_SIZE),
        .COEFF_SIZE(COEFF_SIZE)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sample(in_sample),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_wdata(coef_wdata),
        .mac_mult_en(mac_mult_en),
        .mac_acc_en(mac_acc_en),
        .mac_c(mac_c),
        .mac_s(mac_s),
        .mac_dout(mac_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sample(out_sample),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Shared MAC model: registered product, then a free-running accumulator, reset on the same net.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mac_prod <= '0;
            mac_acc  <= '0;
        end else begin
            if (mac_mult_en) mac_prod <= $signed(mac_s) * $signed(mac_c);
            if (mac_acc_en)  mac_acc  <= mac_acc + mac_prod;
        end
    end
    assign mac_dout = mac_acc;

    // Stop a stuck run so that it still reports something.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 3 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic signed [63:0] observed, input longint expected);
        cmp_cnt++;
        assert (observed === 64'(expected)) else begin
            err_cnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst      = 1'b0;
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic write_coef(input int addr, input logic [COEFF_SIZE-1:0] val);
        coef_we    = 1'b1;
        coef_addr  = addr[AW-1:0];
        coef_wdata = val;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Offer one sample, then wait for out_valid and report the cycle count since the accept.
    task automatic apply_stimulus(input logic [SAMPLE_SIZE-1:0] val, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b1;
        in_sample = val;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_sample(input string tag, input logic [SAMPLE_SIZE-1:0] val,
                              input longint exp_sample, input logic exp_sat);
        int lat;
        apply_stimulus(val, lat);
        check_output({tag, " out_valid"}, {63'd0, out_valid}, 1);
        check_output({tag, " out_sample"}, $signed(out_sample), exp_sample);
        check_output({tag, " out_sat"}, {63'd0, out_sat}, longint'(exp_sat));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        longint sum;
        longint r;
        int v;

        $display("[TB] starting lms_fir_sequencer bench");

        // Reset values and the basic half-gain case with a latency check.
        do_reset();
        check_output("rst in_ready", {63'd0, in_ready}, 1);
        check_output("rst out_valid", {63'd0, out_valid}, 0);
        check_output("rst out_sat", {63'd0, out_sat}, 0);
        check_output("rst out_sample", $signed(out_sample), 0);
        check_output("rst mac_mult_en", {63'd0, mac_mult_en}, 0);
        check_output("rst mac_acc_en", {63'd0, mac_acc_en}, 0);
        check_output("rst mac_c", {47'd0, mac_c}, 0);
        check_output("rst mac_s", {48'd0, mac_s}, 0);
        write_coef(0, 17'h08000);
        apply_stimulus(16'sd1000, lat);
        check_output("t1 latency", longint'(lat), N_TAPS + 3);
        check_output("t1 out_sample", $signed(out_sample), 500);
        check_output("t1 out_sat", {63'd0, out_sat}, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("t1 out_valid drop", {63'd0, out_valid}, 0);

        // An impulse walks through a ramp of coefficients, so output n is 256*n.
        do_reset();
        for (int k = 0; k < N_TAPS; k++) write_coef(k, 17'(k * 1024));
        for (int n = 0; n < N_TAPS; n++) begin
            run_sample($sformatf("t2 n%0d", n), (n == 0) ? 16'sd16384 : 16'sd0, longint'(256 * n), 1'b0);
        end

        // Saturation: a single full-scale sample is in range, and two together clip.
        do_reset();
        for (int k = 0; k < N_TAPS; k++) write_coef(k, 17'h0FFFF);
        run_sample("t3 pos1", 16'h7FFF, 32767, 1'b0);
        run_sample("t3 pos2", 16'h7FFF, 32767, 1'b1);
        do_reset();
        for (int k = 0; k < N_TAPS; k++) write_coef(k, 17'h0FFFF);
        run_sample("t3 neg1", 16'h8000, -32767, 1'b0);
        run_sample("t3 neg2", 16'h8000, -32768, 1'b1);

        // Round-half-up on exact halves.
        do_reset();
        write_coef(0, 17'h08000);
        run_sample("t4 in3", 16'sd3, 2, 1'b0);
        run_sample("t4 in-3", -16'sd3, -1, 1'b0);
        run_sample("t4 in1", 16'sd1, 1, 1'b0);

        // Back-pressure in OUT: output held, no sample consumed, coefficient write dropped.
        do_reset();
        write_coef(0, 17'h08000);
        write_coef(1, 17'h08000);
        apply_stimulus(16'sd1000, lat);
        check_output("t5 first valid", {63'd0, out_valid}, 1);
        in_valid   = 1'b1;
        in_sample  = 16'sd2000;
        coef_we    = 1'b1;
        coef_addr  = '0;
        coef_wdata = 17'h04000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_output($sformatf("t5 hold%0d out_valid", c), {63'd0, out_valid}, 1);
            check_output($sformatf("t5 hold%0d out_sample", c), $signed(out_sample), 500);
            check_output($sformatf("t5 hold%0d in_ready", c), {63'd0, in_ready}, 0);
        end
        coef_we   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_output("t5 out_valid drop", {63'd0, out_valid}, 0);
        run_sample("t5 next", 16'sd200, 600, 1'b0);

        // Long run against the reference FIR; the accumulator wraps many times.
        do_reset();
        for (int k = 0; k < N_TAPS; k++) begin
            ref_x[k] = 0;
            ref_c[k] = 0;
        end
        ref_c[0] = 65535;
        ref_c[1] = 65535;
        ref_c[5] = -100;
        write_coef(0, 17'h0FFFF);
        write_coef(1, 17'h0FFFF);
        write_coef(5, 17'h1FF9C);
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 32767));
            if (i % 7 == 0) v = 32767;
            for (int k = N_TAPS - 1; k > 0; k--) ref_x[k] = ref_x[k-1];
            ref_x[0] = longint'(v);
            sum = 0;
            for (int k = 0; k < N_TAPS; k++) sum += ref_x[k] * ref_c[k];
            r = (sum + 32768) >>> 16;
            if (r > 32767) run_sample($sformatf("t6 s%0d", i), 16'(v), 32767, 1'b1);
            else if (r < -32768) run_sample($sformatf("t6 s%0d", i), 16'(v), -32768, 1'b1);
            else run_sample($sformatf("t6 s%0d", i), 16'(v), r, 1'b0);
        end

        // Reset in the middle of RUN drops the sample; the next one starts clean.
        in_valid  = 1'b1;
        in_sample = 16'sd5000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_output("t6 midrun busy", {63'd0, in_ready}, 0);
        do_reset();
        check_output("t6 post-rst mult_en", {63'd0, mac_mult_en}, 0);
        check_output("t6 post-rst in_ready", {63'd0, in_ready}, 1);
        write_coef(0, 17'h08000);
        run_sample("t6 after rst", 16'sd100, 50, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
